// File: rtl/l2d_pkg.sv
// Shared definitions for both ends of the D2L serial link.
//   rx_state_e  : receiver FSM states
//   LINE_IDLE   : level of an idle line
//   START_BIT   : level of the start bit
//   STOP_BIT    : level of the stop bit
//   even_parity : even-parity bit of a payload, zero-extended to 64 bits by the caller
package l2d_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StBreak
  } rx_state_e;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Zero padding does not change the XOR, so any payload width up to 64 can share this.
  function automatic logic even_parity(input logic [63:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit line entering the clk_i domain.
//   clk_i : destination clock
//   rst_i : asynchronous active-high reset; both flops reset to the idle line level
//   d_i   : asynchronous input
//   q_o   : synchronized output, d_i delayed by two clk_i edges
module sync_2ff
  import l2d_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= LINE_IDLE;
      sync_q <= LINE_IDLE;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/l2d_rx.sv
// Link-to-data receiver: recovers one framed word (start, DATA_W bits MSB first, optional
// even parity, stop) from the serial line and holds it on DATA_OUT until acknowledged.
//   clk, rst  : clock and asynchronous active-high reset
//   link_rx   : serial line, idle high, asynchronous to clk
//   rd_en     : one-cycle acknowledge; clears DONE, FRM_ERR and OVERRUN
//   DATA_OUT  : last good received word
//   DONE      : word available until rd_en
//   PAR_ERR   : parity mismatch on the word in DATA_OUT
//   FRM_ERR   : sticky, stop bit sampled low
//   OVERRUN   : sticky, word committed while DONE was still high
//   BUSY      : receiver not idle
module l2d_rx
  import l2d_pkg::*;
#(
  parameter int unsigned DATA_W       = 64,
  parameter int unsigned CLKS_PER_BIT = 8,
  parameter int unsigned PARITY_EN    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              link_rx,
  input  logic              rd_en,
  output logic [DATA_W-1:0] DATA_OUT,
  output logic              DONE,
  output logic              PAR_ERR,
  output logic              FRM_ERR,
  output logic              OVERRUN,
  output logic              BUSY
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BitW = $clog2(DATA_W);
  localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] CntLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [BitW-1:0] BitLast  = BitW'(DATA_W - 1);

  logic rx_s;

  sync_2ff u_sync (
    .clk_i (clk),
    .rst_i (rst),
    .d_i   (link_rx),
    .q_o   (rx_s)
  );

  rx_state_e         state_q, state_d;
  logic [CntW-1:0]   clk_cnt_q, clk_cnt_d;
  logic [BitW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_bad_q, par_bad_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              done_q, done_d;
  logic              par_err_q, par_err_d;
  logic              frm_err_q, frm_err_d;
  logic              overrun_q, overrun_d;

  logic start_tick, bit_tick, commit, frm_fail;

  // Start bit is checked half a bit in; every later bit one full bit after the previous one.
  assign start_tick = (clk_cnt_q == HalfLast);
  assign bit_tick   = (clk_cnt_q == CntLast);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q + 1'b1;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_bad_d = par_bad_q;
    unique case (state_q)
      StIdle: begin
        clk_cnt_d = '0;
        if (rx_s == START_BIT) state_d = StStart;
      end
      StStart: begin
        if (start_tick) begin
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          state_d   = (rx_s == START_BIT) ? StData : StIdle;
        end
      end
      StData: begin
        if (bit_tick) begin
          clk_cnt_d = '0;
          shift_d   = {shift_q[DATA_W-2:0], rx_s};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BitLast) state_d = (PARITY_EN != 0) ? StParity : StStop;
        end
      end
      StParity: begin
        if (bit_tick) begin
          clk_cnt_d = '0;
          par_bad_d = even_parity(64'(shift_q)) ^ rx_s;
          state_d   = StStop;
        end
      end
      StStop: begin
        if (bit_tick) begin
          clk_cnt_d = '0;
          // Straight back to idle so a start bit right after the stop bit is not missed.
          state_d   = (rx_s == STOP_BIT) ? StIdle : StBreak;
        end
      end
      StBreak: begin
        clk_cnt_d = '0;
        if (rx_s == LINE_IDLE) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    commit   = (state_q == StStop) && bit_tick && (rx_s == STOP_BIT);
    frm_fail = (state_q == StStop) && bit_tick && (rx_s != STOP_BIT);
    BUSY     = (state_q != StIdle);

    data_d    = data_q;
    par_err_d = par_err_q;
    done_d    = done_q;
    overrun_d = overrun_q;
    frm_err_d = frm_err_q;
    // A commit on the same edge as rd_en wins: the new word stays flagged as available.
    if (commit) begin
      data_d    = shift_q;
      par_err_d = par_bad_q;
      done_d    = 1'b1;
    end else if (rd_en) begin
      done_d = 1'b0;
    end
    if (commit && done_q && !rd_en) begin
      overrun_d = 1'b1;
    end else if (rd_en) begin
      overrun_d = 1'b0;
    end
    if (frm_fail) begin
      frm_err_d = 1'b1;
    end else if (rd_en) begin
      frm_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_bad_q <= 1'b0;
      data_q    <= '0;
      done_q    <= 1'b0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_bad_q <= par_bad_d;
      data_q    <= data_d;
      done_q    <= done_d;
      par_err_q <= par_err_d;
      frm_err_q <= frm_err_d;
      overrun_q <= overrun_d;
    end
  end

  assign DATA_OUT = data_q;
  assign DONE     = done_q;
  assign PAR_ERR  = par_err_q;
  assign FRM_ERR  = frm_err_q;
  assign OVERRUN  = overrun_q;

endmodule
